// File: rtl/interrupt_controller_if.sv
// CPU-side bus of the interrupt controller: register access, dispatch handshake
// and the pending/wake/vector outputs seen by the core.
interface interrupt_controller_if #(
  parameter int N_CHANNELS = 5
);
  logic [15:0]           i_Address;
  logic [7:0]            i_Data;
  logic                  i_Write;
  logic                  i_Read;
  logic                  i_IME;
  logic                  i_Ack;
  logic [N_CHANNELS-1:0] o_Pending;
  logic                  o_Wake;
  logic [15:0]           o_Vector;
  logic [7:0]            o_Data;
  logic                  o_Data_Valid;

  modport master (
    output i_Address, i_Data, i_Write, i_Read, i_IME, i_Ack,
    input  o_Pending, o_Wake, o_Vector, o_Data, o_Data_Valid
  );

  modport slave (
    input  i_Address, i_Data, i_Write, i_Read, i_IME, i_Ack,
    output o_Pending, o_Wake, o_Vector, o_Data, o_Data_Valid
  );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: flag/enable registers, fixed lowest-index
// priority and an IDLE/SERVICE dispatch FSM that latches the service vector.
module interrupt_controller #(
  parameter int          N_CHANNELS    = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008,
  parameter logic [15:0] ADDR_IF       = 16'hFF0F,
  parameter logic [15:0] ADDR_IE       = 16'hFFFF
) (
  input  logic                  i_Clk,
  input  logic                  i_nRst,
  input  logic                  i_Enable,
  input  logic [N_CHANNELS-1:0] i_Request,
  interrupt_controller_if.slave bus
);
  localparam int IW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  typedef enum logic {ST_IDLE, ST_SERVICE} state_t;

  state_t                r_State;
  state_t                w_State_Next;
  logic                  w_Dispatch;
  logic [N_CHANNELS-1:0] r_IF;
  logic [N_CHANNELS-1:0] r_IE;
  logic [N_CHANNELS-1:0] r_Prev;
  logic [15:0]           r_Vector;
  logic [7:0]            r_Data;
  logic                  r_Data_Valid;

  logic [N_CHANNELS-1:0] w_Edge;
  logic [N_CHANNELS-1:0] w_Active;
  logic [N_CHANNELS-1:0] w_Grant;
  logic [N_CHANNELS-1:0] w_IF_Next;
  logic [N_CHANNELS-1:0] w_IE_Next;
  logic [IW-1:0]         w_Idx;
  logic [15:0]           w_Vec;
  logic [7:0]            w_Rd_IF;
  logic [7:0]            w_Rd_IE;
  logic                  w_Wr_IF;
  logic                  w_Wr_IE;
  logic                  w_unused_data;

  assign w_Edge   = i_Request & ~r_Prev;
  assign w_Active = r_IF & r_IE;
  // Isolates the lowest set bit: that channel wins arbitration.
  assign w_Grant  = w_Active & (~w_Active + 1'b1);
  assign w_Wr_IF  = bus.i_Write && (bus.i_Address == ADDR_IF);
  assign w_Wr_IE  = bus.i_Write && (bus.i_Address == ADDR_IE);
  assign w_Vec    = VECTOR_BASE + VECTOR_STRIDE * 16'(w_Idx);
  assign w_unused_data = &{1'b0, bus.i_Data};

  always_comb begin
    w_Idx = '0;
    for (int k = N_CHANNELS - 1; k >= 0; k--) begin
      if (w_Active[k]) w_Idx = IW'(k);
    end
  end

  always_comb begin
    w_Rd_IF = '1;
    w_Rd_IF[N_CHANNELS-1:0] = r_IF;
    w_Rd_IE = '0;
    w_Rd_IE[N_CHANNELS-1:0] = r_IE;
  end

  // Write first, then dispatch clear, then new edges: an edge always survives.
  always_comb begin
    w_IF_Next = r_IF;
    if (w_Wr_IF) w_IF_Next = bus.i_Data[N_CHANNELS-1:0];
    if (w_Dispatch) w_IF_Next = w_IF_Next & ~w_Grant;
    w_IF_Next = w_IF_Next | w_Edge;
    w_IE_Next = w_Wr_IE ? bus.i_Data[N_CHANNELS-1:0] : r_IE;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_nRst) begin
      r_State <= ST_IDLE;
    end else if (i_Enable) begin
      r_State <= w_State_Next;
    end
  end

  always_comb begin
    w_State_Next = r_State;
    w_Dispatch   = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (bus.i_Ack) begin
          w_State_Next = ST_SERVICE;
          w_Dispatch   = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (!bus.i_Ack) w_State_Next = ST_IDLE;
      end
      default: w_State_Next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_nRst) begin
      r_IF         <= '0;
      r_IE         <= '0;
      r_Prev       <= i_Request;
      r_Vector     <= '0;
      r_Data       <= '0;
      r_Data_Valid <= 1'b0;
    end else if (i_Enable) begin
      r_Prev <= i_Request;
      r_IF   <= w_IF_Next;
      r_IE   <= w_IE_Next;
      // A dispatch with nothing pending is cancelled and reports vector 0.
      if (w_Dispatch) r_Vector <= (|w_Active) ? w_Vec : 16'h0000;
      if (bus.i_Read && (bus.i_Address == ADDR_IF)) begin
        r_Data       <= w_Rd_IF;
        r_Data_Valid <= 1'b1;
      end else if (bus.i_Read && (bus.i_Address == ADDR_IE)) begin
        r_Data       <= w_Rd_IE;
        r_Data_Valid <= 1'b1;
      end else begin
        r_Data_Valid <= 1'b0;
      end
    end
  end

  assign bus.o_Pending    = (r_State == ST_SERVICE) ? '0 : (w_Active & {N_CHANNELS{bus.i_IME}});
  assign bus.o_Wake       = |w_Active;
  assign bus.o_Vector     = r_Vector;
  assign bus.o_Data       = r_Data;
  assign bus.o_Data_Valid = r_Data_Valid;
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter N_CHANNELS, default 5, number of interrupt sources; legal range 1..8.
REQ-002 Parameter VECTOR_BASE, default 16'h0040, service address of channel 0.
REQ-003 Parameter VECTOR_STRIDE, default 16'h0008, address step between consecutive channel vectors.
REQ-004 Parameter ADDR_IF, default 16'hFF0F, memory address of the flag register.
REQ-005 Parameter ADDR_IE, default 16'hFFFF, memory address of the enable register.
REQ-006 i_Clk  in  1  system clock; single clock domain, all state on rising edge.
REQ-007 i_nRst  in  1  reset, synchronous, active-low.
REQ-008 i_Enable  in  1  clock enable; no state changes when 0, except reset.
REQ-009 i_Request  in  N_CHANNELS  raw interrupt source lines; rising edge raises a request.
REQ-010 i_Address  in  16  CPU memory address.
REQ-011 i_Data  in  8  CPU write data.
REQ-012 i_Write  in  1  CPU write strobe, one cycle per write.
REQ-013 i_Read  in  1  CPU read strobe.
REQ-014 i_IME  in  1  CPU master interrupt enable.
REQ-015 i_Ack  in  1  CPU dispatch acknowledge, held high for the duration of dispatch.
REQ-016 o_Pending  out  N_CHANNELS  IF & IE & {N{i_IME}}, masked to 0 while in SERVICE; feeds CPU i_Interrupts.
REQ-017 o_Wake  out  1  |(IF & IE), independent of i_IME and state; halt wake-up.
REQ-018 o_Vector  out  16  service address latched at dispatch.
REQ-019 o_Data  out  8  registered read data.
REQ-020 o_Data_Valid  out  1  high for one cycle when o_Data holds a decoded register read.

Function
REQ-021 Edge detect: a per-channel previous-value register; IF[k] sets when i_Request[k]=1 and previous=0, sampled only when i_Enable=1.
REQ-022 Write to ADDR_IF loads IF <= i_Data[N-1:0]; write to ADDR_IE loads IE <= i_Data[N-1:0]; other addresses ignored.
REQ-023 Same-cycle write to IF and edge on bit k: IF[k]=1 (set wins).
REQ-024 Read at ADDR_IF: next-cycle o_Data = {unused bits forced 1, IF}; at ADDR_IE: {unused bits 0, IE}; o_Data_Valid=1 that cycle; non-matching address: o_Data_Valid=0, o_Data holds.
REQ-025 Priority: lowest-index bit of (IF & IE) wins.
REQ-026 States: IDLE, SERVICE.
REQ-027 IDLE -> SERVICE on i_Ack=1 (with i_Enable=1): latch winning index, clear its IF bit, o_Vector <= VECTOR_BASE + index*VECTOR_STRIDE, truncated mod 2^16.
REQ-028 Ack with (IF & IE)=0: enter SERVICE, o_Vector <= 16'h0000, no IF bit cleared (cancelled dispatch).
REQ-029 Same-cycle dispatch clear and new edge on the same channel: IF bit stays 1.
REQ-030 Same-cycle dispatch clear and CPU IF write: write applies, then dispatch clears the granted bit, then new edges set.
REQ-031 SERVICE -> IDLE on i_Ack=0; o_Vector holds its value until the next dispatch.
REQ-032 In SERVICE, edges and register writes still update IF/IE; no second dispatch until the FSM returns to IDLE.
REQ-033 Dispatch latency: o_Vector valid and IF bit cleared one clock after the first i_Ack=1 cycle.

Reset
REQ-034 On i_Clk edge with i_nRst=0, regardless of i_Enable: IF=0, IE=0, edge registers <= current i_Request, state=IDLE, o_Vector=0, o_Data=0, o_Data_Valid=0.
REQ-035 Reset during SERVICE aborts dispatch; first cycle after reset has o_Pending=0 and o_Wake=0.
REQ-036 A source held high through reset does not raise a request after reset.

Verification
REQ-037 Defaults: write IE=8'h1F, i_IME=1, rising edges on bits 1 and 3 together -> o_Pending=5'b01010; i_Ack -> o_Vector=16'h0048, IF=5'b01000.
REQ-038 Edge on bit 2 in the same cycle as write IF=8'h00 -> IF read returns 8'hE4, o_Data_Valid pulses once.
REQ-039 i_IME=0, IE=8'h01, edge on bit 0 -> o_Pending=0, o_Wake=1; i_Ack -> o_Vector=16'h0040, IF=0.
REQ-040 i_Ack with IF=0 -> o_Vector=16'h0000, state SERVICE; edges during SERVICE keep o_Pending=0 until i_Ack drops.
REQ-041 N_CHANNELS=8, VECTOR_BASE=16'hFFF0, VECTOR_STRIDE=16'h0004, edge on bit 7 and dispatch -> o_Vector=16'h000C (wrap).
REQ-042 i_nRst=0 mid-SERVICE with i_Request[0] held high -> all outputs 0 next cycle; no IF[0] set after release until i_Request[0] falls and rises again.
